// File: rtl/ysyx_23060075_mem_arbiter.sv
// Two-to-one round-robin arbiter that shares one memory port between IFU and LSU.
// It keeps one transaction outstanding and aborts it with a watchdog if no response arrives.
module ysyx_23060075_mem_arbiter #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int MASK_WIDTH     = DATA_WIDTH / 8,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ifu_req_valid,
  output logic                  ifu_req_ready,
  input  logic [ADDR_WIDTH-1:0] ifu_addr,
  output logic                  ifu_resp_valid,
  output logic [DATA_WIDTH-1:0] ifu_rdata,
  input  logic                  lsu_req_valid,
  output logic                  lsu_req_ready,
  input  logic [ADDR_WIDTH-1:0] lsu_addr,
  input  logic                  lsu_wen,
  input  logic [DATA_WIDTH-1:0] lsu_wdata,
  input  logic [MASK_WIDTH-1:0] lsu_wmask,
  output logic                  lsu_resp_valid,
  output logic [DATA_WIDTH-1:0] lsu_rdata,
  output logic                  mem_req_valid,
  input  logic                  mem_req_ready,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_wen,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic [MASK_WIDTH-1:0] mem_wmask,
  input  logic                  mem_resp_valid,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  timeout_err
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic OWN_IFU = 1'b0;
  localparam logic OWN_LSU = 1'b1;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_t;

  state_t                state_q, state_d;
  logic                  owner_q, owner_d;
  logic                  last_grant_q, last_grant_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  wen_q, wen_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [MASK_WIDTH-1:0] wmask_q, wmask_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  timeout_q, timeout_d;
  logic                  abort;
  logic                  ifu_win, lsu_win;

  // On a tie, the requester that was not granted last wins.
  assign lsu_win = lsu_req_valid && (!ifu_req_valid || (last_grant_q == OWN_IFU));
  assign ifu_win = ifu_req_valid && (!lsu_req_valid || (last_grant_q == OWN_LSU));

  always_comb begin
    state_d        = state_q;
    owner_d        = owner_q;
    last_grant_d   = last_grant_q;
    addr_d         = addr_q;
    wen_d          = wen_q;
    wdata_d        = wdata_q;
    wmask_d        = wmask_q;
    cnt_d          = cnt_q;
    timeout_d      = timeout_q;
    abort          = 1'b0;
    ifu_req_ready  = 1'b0;
    lsu_req_ready  = 1'b0;
    ifu_resp_valid = 1'b0;
    lsu_resp_valid = 1'b0;
    ifu_rdata      = '0;
    lsu_rdata      = '0;
    unique case (state_q)
      S_IDLE: begin
        if (!rst && lsu_win) begin
          lsu_req_ready = 1'b1;
          owner_d       = OWN_LSU;
          last_grant_d  = OWN_LSU;
          addr_d        = lsu_addr;
          wen_d         = lsu_wen;
          wdata_d       = lsu_wdata;
          wmask_d       = lsu_wmask;
          state_d       = S_REQ;
        end else if (!rst && ifu_win) begin
          ifu_req_ready = 1'b1;
          owner_d       = OWN_IFU;
          last_grant_d  = OWN_IFU;
          addr_d        = ifu_addr;
          wen_d         = 1'b0;
          wdata_d       = '0;
          wmask_d       = '0;
          state_d       = S_REQ;
        end
      end
      S_REQ: begin
        if (mem_req_ready) begin
          cnt_d   = '0;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        // A response in the final watchdog cycle wins over the abort.
        if (!rst && mem_resp_valid) begin
          if (owner_q == OWN_LSU) begin
            lsu_resp_valid = 1'b1;
            lsu_rdata      = wen_q ? '0 : mem_rdata;
          end else begin
            ifu_resp_valid = 1'b1;
            ifu_rdata      = mem_rdata;
          end
          state_d = S_IDLE;
        end else if (!rst && (cnt_q == CNT_LAST)) begin
          abort          = 1'b1;
          timeout_d      = 1'b1;
          lsu_resp_valid = (owner_q == OWN_LSU);
          ifu_resp_valid = (owner_q == OWN_IFU);
          state_d        = S_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      owner_q      <= OWN_IFU;
      last_grant_q <= OWN_IFU;
      addr_q       <= '0;
      wen_q        <= 1'b0;
      wdata_q      <= '0;
      wmask_q      <= '0;
      cnt_q        <= '0;
      timeout_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
      addr_q       <= addr_d;
      wen_q        <= wen_d;
      wdata_q      <= wdata_d;
      wmask_q      <= wmask_d;
      cnt_q        <= cnt_d;
      timeout_q    <= timeout_d;
    end
  end

  assign mem_req_valid = (state_q == S_REQ);
  assign mem_addr      = addr_q;
  assign mem_wen       = wen_q;
  assign mem_wdata     = wdata_q;
  assign mem_wmask     = wmask_q;
  assign timeout_err   = timeout_q | abort;

endmodule

// File: tb/tb_ysyx_23060075_mem_arbiter.sv
// Directed bench for the memory arbiter: single reads/writes, round-robin order,
// downstream stalls, the watchdog abort and reset while a transaction is in flight.
module tb_ysyx_23060075_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        ifu_req_valid, ifu_req_ready, ifu_resp_valid;
  logic [31:0] ifu_addr, ifu_rdata;
  logic        lsu_req_valid, lsu_req_ready, lsu_wen, lsu_resp_valid;
  logic [31:0] lsu_addr, lsu_wdata, lsu_rdata;
  logic [3:0]  lsu_wmask;
  logic        mem_req_valid, mem_req_ready, mem_wen, mem_resp_valid, timeout_err;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_wmask;

  int total = 0;
  int bad   = 0;

  ysyx_23060075_mem_arbiter #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32), .MASK_WIDTH(4), .TIMEOUT_CYCLES(4)
  ) dut (
    .clk(clk), .rst(rst),
    .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_addr(ifu_addr),
    .ifu_resp_valid(ifu_resp_valid), .ifu_rdata(ifu_rdata),
    .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_addr(lsu_addr),
    .lsu_wen(lsu_wen), .lsu_wdata(lsu_wdata), .lsu_wmask(lsu_wmask),
    .lsu_resp_valid(lsu_resp_valid), .lsu_rdata(lsu_rdata),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_addr(mem_addr),
    .mem_wen(mem_wen), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
    .mem_resp_valid(mem_resp_valid), .mem_rdata(mem_rdata),
    .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one cycle; inputs are then changed 1 time unit after the edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Let combinational outputs settle before sampling.
  task automatic settle();
    #2;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    rst = 1'b1;
    ifu_req_valid = 1'b1; ifu_addr = 32'h0;
    lsu_req_valid = 1'b0; lsu_addr = 32'h0; lsu_wen = 1'b0; lsu_wdata = 32'h0; lsu_wmask = 4'h0;
    mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_rdata = 32'h0;
    repeat (2) @(posedge clk);
    #1; settle();
    // reset values, with a request pending that must not be accepted
    chk("rst_ifu_ready", 64'(ifu_req_ready), 64'd0);
    chk("rst_lsu_ready", 64'(lsu_req_ready), 64'd0);
    chk("rst_mem_valid", 64'(mem_req_valid), 64'd0);
    chk("rst_mem_addr", 64'(mem_addr), 64'd0);
    chk("rst_mem_wen", 64'(mem_wen), 64'd0);
    chk("rst_timeout", 64'(timeout_err), 64'd0);
    chk("rst_ifu_resp", 64'(ifu_resp_valid), 64'd0);
    chk("rst_ifu_rdata", 64'(ifu_rdata), 64'd0);
    $display("txn reset: checked reset outputs");
    ifu_req_valid = 1'b0;
    @(negedge clk); rst = 1'b0;
    cyc();

    // Single IFU read, zero-wait memory
    ifu_req_valid = 1'b1; ifu_addr = 32'h8000_0000; settle();
    chk("t1_ifu_ready", 64'(ifu_req_ready), 64'd1);
    chk("t1_lsu_ready", 64'(lsu_req_ready), 64'd0);
    cyc();
    ifu_req_valid = 1'b0; ifu_addr = 32'h0; mem_req_ready = 1'b1; settle();
    chk("t1_mem_valid", 64'(mem_req_valid), 64'd1);
    chk("t1_mem_addr", 64'(mem_addr), 64'h8000_0000);
    chk("t1_mem_wen", 64'(mem_wen), 64'd0);
    chk("t1_mem_wmask", 64'(mem_wmask), 64'd0);
    chk("t1_ifu_ready_req", 64'(ifu_req_ready), 64'd0);
    cyc();
    mem_req_ready = 1'b0; mem_resp_valid = 1'b1; mem_rdata = 32'h0010_0073; settle();
    chk("t1_ifu_resp", 64'(ifu_resp_valid), 64'd1);
    chk("t1_ifu_rdata", 64'(ifu_rdata), 64'h0010_0073);
    chk("t1_lsu_resp", 64'(lsu_resp_valid), 64'd0);
    chk("t1_mem_valid_wait", 64'(mem_req_valid), 64'd0);
    cyc();
    settle();  // mem_resp_valid still high while IDLE: ignored
    chk("t1_idle_resp_ignored", 64'(ifu_resp_valid), 64'd0);
    chk("t1_idle_rdata_zero", 64'(ifu_rdata), 64'd0);
    $display("txn ifu_read addr=80000000 rdata=%08h", 32'h0010_0073);
    mem_resp_valid = 1'b0;
    cyc();

    // LSU write
    lsu_req_valid = 1'b1; lsu_addr = 32'h8000_1000; lsu_wen = 1'b1;
    lsu_wdata = 32'hDEAD_BEEF; lsu_wmask = 4'hF; settle();
    chk("t2_lsu_ready", 64'(lsu_req_ready), 64'd1);
    cyc();
    lsu_req_valid = 1'b0; lsu_wdata = 32'h0; lsu_wmask = 4'h0; mem_req_ready = 1'b1; settle();
    chk("t2_mem_valid", 64'(mem_req_valid), 64'd1);
    chk("t2_mem_addr", 64'(mem_addr), 64'h8000_1000);
    chk("t2_mem_wen", 64'(mem_wen), 64'd1);
    chk("t2_mem_wdata", 64'(mem_wdata), 64'hDEAD_BEEF);
    chk("t2_mem_wmask", 64'(mem_wmask), 64'hF);
    cyc();
    mem_req_ready = 1'b0; mem_resp_valid = 1'b1; mem_rdata = 32'h1234_5678; settle();
    chk("t2_lsu_resp", 64'(lsu_resp_valid), 64'd1);
    chk("t2_lsu_rdata", 64'(lsu_rdata), 64'd0);
    chk("t2_ifu_resp", 64'(ifu_resp_valid), 64'd0);
    $display("txn lsu_write addr=80001000 wdata=deadbeef");
    cyc();
    mem_resp_valid = 1'b0; lsu_wen = 1'b0;

    // Reset, then both requesters continuously valid: LSU, IFU, LSU, ...
    rst = 1'b1; cyc(); rst = 1'b0;
    ifu_req_valid = 1'b1; ifu_addr = 32'h0000_1000;
    lsu_req_valid = 1'b1; lsu_addr = 32'h0000_2000; lsu_wen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      logic exp_lsu;
      exp_lsu = (i % 2 == 0);
      settle();
      chk($sformatf("t3_lsu_ready_%0d", i), 64'(lsu_req_ready), 64'(exp_lsu));
      chk($sformatf("t3_ifu_ready_%0d", i), 64'(ifu_req_ready), 64'(!exp_lsu));
      cyc();
      mem_req_ready = 1'b1; settle();
      chk($sformatf("t3_mem_addr_%0d", i), 64'(mem_addr), exp_lsu ? 64'h2000 : 64'h1000);
      chk($sformatf("t3_no_ready_req_%0d", i), 64'(ifu_req_ready | lsu_req_ready), 64'd0);
      cyc();
      mem_req_ready = 1'b0; mem_resp_valid = 1'b1; mem_rdata = 32'hA0 + 32'(i); settle();
      chk($sformatf("t3_lsu_resp_%0d", i), 64'(lsu_resp_valid), 64'(exp_lsu));
      chk($sformatf("t3_ifu_resp_%0d", i), 64'(ifu_resp_valid), 64'(!exp_lsu));
      chk($sformatf("t3_rdata_%0d", i), 64'(exp_lsu ? lsu_rdata : ifu_rdata), 64'(32'hA0 + 32'(i)));
      $display("txn rr %0d owner=%s", i, exp_lsu ? "LSU" : "IFU");
      cyc();
      mem_resp_valid = 1'b0;
    end
    ifu_req_valid = 1'b0; lsu_req_valid = 1'b0;

    // Downstream stall for 5 cycles, response 3 cycles after acceptance
    ifu_req_valid = 1'b1; ifu_addr = 32'h8000_0040; settle();
    chk("t4_ifu_ready", 64'(ifu_req_ready), 64'd1);
    cyc();
    ifu_req_valid = 1'b0; ifu_addr = 32'hFFFF_FFFF;
    for (int i = 0; i < 5; i++) begin
      settle();
      chk($sformatf("t4_stall_valid_%0d", i), 64'(mem_req_valid), 64'd1);
      chk($sformatf("t4_stall_addr_%0d", i), 64'(mem_addr), 64'h8000_0040);
      cyc();
    end
    mem_req_ready = 1'b1; settle();
    chk("t4_accept_valid", 64'(mem_req_valid), 64'd1);
    cyc();
    mem_req_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      settle();
      chk($sformatf("t4_wait_noresp_%0d", i), 64'(ifu_resp_valid), 64'd0);
      chk($sformatf("t4_wait_valid_%0d", i), 64'(mem_req_valid), 64'd0);
      cyc();
    end
    mem_resp_valid = 1'b1; mem_rdata = 32'hCAFE_F00D; settle();
    chk("t4_resp", 64'(ifu_resp_valid), 64'd1);
    chk("t4_rdata", 64'(ifu_rdata), 64'hCAFE_F00D);
    cyc();
    mem_resp_valid = 1'b0; settle();
    chk("t4_single_pulse", 64'(ifu_resp_valid), 64'd0);
    $display("txn stall ifu_read addr=80000040 rdata=cafef00d");
    cyc();

    // Response in the 4th WAIT cycle beats the abort
    ifu_req_valid = 1'b1; ifu_addr = 32'h0000_0500; cyc();
    ifu_req_valid = 1'b0; mem_req_ready = 1'b1; cyc();
    mem_req_ready = 1'b0;
    repeat (3) cyc();
    mem_resp_valid = 1'b1; mem_rdata = 32'h0000_0055; settle();
    chk("t5_edge_resp", 64'(ifu_resp_valid), 64'd1);
    chk("t5_edge_rdata", 64'(ifu_rdata), 64'h55);
    chk("t5_edge_no_timeout", 64'(timeout_err), 64'd0);
    cyc();
    mem_resp_valid = 1'b0; settle();
    chk("t5_edge_timeout_after", 64'(timeout_err), 64'd0);
    $display("txn edge ifu_read addr=00000500 rdata=00000055");

    // LSU read with no response: abort at the 4th WAIT cycle
    lsu_req_valid = 1'b1; lsu_addr = 32'h0000_0300; lsu_wen = 1'b0; cyc();
    lsu_req_valid = 1'b0; mem_req_ready = 1'b1; cyc();
    mem_req_ready = 1'b0; mem_rdata = 32'hFFFF_FFFF;
    for (int i = 0; i < 3; i++) begin
      settle();
      chk($sformatf("t6_wait_noresp_%0d", i), 64'(lsu_resp_valid), 64'd0);
      chk($sformatf("t6_wait_noerr_%0d", i), 64'(timeout_err), 64'd0);
      cyc();
    end
    settle();
    chk("t6_abort_resp", 64'(lsu_resp_valid), 64'd1);
    chk("t6_abort_rdata", 64'(lsu_rdata), 64'd0);
    chk("t6_abort_ifu_resp", 64'(ifu_resp_valid), 64'd0);
    chk("t6_abort_err", 64'(timeout_err), 64'd1);
    cyc();
    mem_resp_valid = 1'b1; settle();
    chk("t6_late_lsu", 64'(lsu_resp_valid), 64'd0);
    chk("t6_late_ifu", 64'(ifu_resp_valid), 64'd0);
    chk("t6_err_sticky", 64'(timeout_err), 64'd1);
    cyc();
    mem_resp_valid = 1'b0;
    repeat (3) cyc();
    settle();
    chk("t6_err_sticky_later", 64'(timeout_err), 64'd1);
    $display("txn timeout lsu_read addr=00000300");
    cyc();

    // Reset while waiting for a response
    ifu_req_valid = 1'b1; ifu_addr = 32'h0000_0400; cyc();
    ifu_req_valid = 1'b0; mem_req_ready = 1'b1; cyc();
    mem_req_ready = 1'b0; rst = 1'b1; cyc();
    rst = 1'b0; mem_resp_valid = 1'b1; mem_rdata = 32'h0000_0077; settle();
    chk("t7_no_ifu_resp", 64'(ifu_resp_valid), 64'd0);
    chk("t7_ifu_rdata", 64'(ifu_rdata), 64'd0);
    chk("t7_mem_valid", 64'(mem_req_valid), 64'd0);
    chk("t7_mem_addr", 64'(mem_addr), 64'd0);
    chk("t7_timeout_clr", 64'(timeout_err), 64'd0);
    cyc();
    mem_resp_valid = 1'b0; settle();
    chk("t7_still_no_resp", 64'(ifu_resp_valid), 64'd0);
    $display("txn reset_in_wait addr=00000400 dropped");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
